// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: parity modes, receiver states and the
// layout of a received word, which is packed as {ferr, perr, data}.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  function automatic int rx_word_width(input int data_bits);
    return data_bits + 2;
  endfunction

  function automatic int rx_perr_pos(input int data_bits);
    return data_bits;
  endfunction

  function automatic int rx_ferr_pos(input int data_bits);
    return data_bits + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received words; a push and a pop in the same
// cycle both succeed even when full.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;
  localparam logic [CNW-1:0] FULL_CNT = CNW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNW-1:0]   cnt_q, cnt_d;
  logic             wr_en, rd_en;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (wr_en) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (rd_en) rd_d = rd_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// Parametrised UART receiver: words tagged with parity/framing errors drain via valid/ready.
// Build option UART_RX_MAJORITY_EN: 2-of-3 vote around each bit centre (decision one cycle later).
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int      CLK_PER_HALF_BIT = 5208,
  parameter int      DATA_BITS        = 8,
  parameter parity_e PARITY           = PAR_NONE,
  parameter int      STOP_BITS        = 1,
  parameter int      FIFO_DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_perr,
  output logic                 m_ferr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  input  logic                 clr_ovr,
  output logic                 busy
);
  // state     | meaning
  // ST_IDLE   | line idle, waiting for rxs low
  // ST_START  | confirming the start bit at its centre
  // ST_DATA   | sampling data bits, LSB first
  // ST_PARITY | sampling the parity bit
  // ST_STOP   | sampling stop bits, word pushed after the last one
  // ST_BREAK  | last stop bit was low; waiting for the line to return high

  localparam int CW   = $clog2(2 * CLK_PER_HALF_BIT);
  localparam int WW   = rx_word_width(DATA_BITS);
  localparam int PPOS = rx_perr_pos(DATA_BITS);
  localparam int FPOS = rx_ferr_pos(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] CNT_SMP = CW'(CLK_PER_HALF_BIT);
`else
  localparam logic [CW-1:0] CNT_SMP = CW'(CLK_PER_HALF_BIT - 1);
`endif

  logic                 meta_q, meta_d, rxs_q, rxs_d;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 push_q, push_d;
  logic                 ovr_q, ovr_d;
  logic                 smp_en, smp_val, par_exp;
  logic                 fifo_full, fifo_empty, pop;
  logic [WW-1:0]        fifo_dout;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;

  always_comb hist_d = {hist_q[0], rxs_q};

  always_ff @(posedge clk) begin
    if (!rstn) hist_q <= 2'b11;
    else       hist_q <= hist_d;
  end

  // hist_q holds rxs at centre-1 and centre when cnt is at centre+1
  assign smp_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
  assign smp_val = rxs_q;
`endif

  assign smp_en  = (cnt_q == CNT_SMP);
  assign par_exp = (^shift_q) ^ (PARITY == PAR_ODD);

  always_comb begin
    meta_d  = rxd;
    rxs_d   = meta_q;
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push_d  = 1'b0;
    ovr_d   = (ovr_q & ~clr_ovr) | (push_q & fifo_full & ~pop);
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) begin
          state_d = ST_START;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (smp_en) state_d = smp_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (smp_en) begin
          shift_d = {smp_val, shift_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (smp_en) begin
          perr_d  = (smp_val != par_exp);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (smp_en) begin
          ferr_d = ferr_q | ~smp_val;
          if (bit_q == STOP_LAST) begin
            push_d  = 1'b1;
            state_d = smp_val ? ST_IDLE : ST_BREAK;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rxs_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      push_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      rxs_q   <= rxs_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      push_q  <= push_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pop = ~fifo_empty & m_ready;

  // Flags and data stay in their registers through the push cycle.
  uart_rx_fifo #(
    .WIDTH(WW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push_q),
    .din  ({ferr_q, perr_q, shift_q}),
    .pop  (pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign m_data  = fifo_dout[DATA_BITS-1:0];
  assign m_perr  = fifo_dout[PPOS];
  assign m_ferr  = fifo_dout[FPOS];
  assign m_valid = ~fifo_empty;
  assign overrun = ovr_q;
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_BREAK);

endmodule

// File: tb/tb_uart_rx_stream.sv
// Bench for uart_rx_stream: an 8N1 instance and a 7E2 instance, random frames
// checked against a queue-based model of the expected received words.
module tb_uart_rx_stream;
  import uart_pkg::*;

  localparam int CPHB    = 4;
  localparam int BIT_CYC = 2 * CPHB;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic       rxd_a = 1'b1, m_ready_a = 1'b0, clr_ovr_a = 1'b0;
  logic [7:0] m_data_a;
  logic       m_perr_a, m_ferr_a, m_valid_a, overrun_a, busy_a;
  logic       rxd_b = 1'b1, m_ready_b = 1'b0, clr_ovr_b = 1'b0;
  logic [6:0] m_data_b;
  logic       m_perr_b, m_ferr_b, m_valid_b, overrun_b, busy_b;

  int n_assert = 0;
  int n_fail = 0;
  logic [9:0] exp_a[$];
  logic [8:0] exp_b[$];
  logic ovr_exp_a = 1'b0;

  uart_rx_stream #(.CLK_PER_HALF_BIT(CPHB), .DATA_BITS(8), .PARITY(PAR_NONE),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rstn(rstn), .rxd(rxd_a), .m_data(m_data_a), .m_perr(m_perr_a),
    .m_ferr(m_ferr_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
    .overrun(overrun_a), .clr_ovr(clr_ovr_a), .busy(busy_a));

  uart_rx_stream #(.CLK_PER_HALF_BIT(CPHB), .DATA_BITS(7), .PARITY(PAR_EVEN),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rstn(rstn), .rxd(rxd_b), .m_data(m_data_b), .m_perr(m_perr_b),
    .m_ferr(m_ferr_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
    .overrun(overrun_b), .clr_ovr(clr_ovr_b), .busy(busy_b));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "time limit reached");
  end

  // Model: a 4-entry FIFO of {ferr, perr, data}; a frame arriving when full is lost.
  task automatic model_a(input logic [7:0] d, input logic stop);
    if (exp_a.size() < 4) exp_a.push_back({~stop, 1'b0, d});
    else ovr_exp_a = 1'b1;
  endtask

  task automatic model_b(input logic [6:0] d, input logic par, input logic s1, input logic s2);
    logic perr, ferr;
    perr = ($countones({d, par}) % 2) != 0;
    ferr = !(s1 && s2);
    if (exp_b.size() < 4) exp_b.push_back({ferr, perr, d});
  endtask

  // Sends one 8N1 frame; glitch_bit inverts one cycle at that bit's centre, cut>0 aborts after cut cycles.
  task automatic tx_a(input logic [7:0] d, input logic stop, input int glitch_bit, input int cut);
    logic [9:0] f;
    int n;
    f = {stop, d, 1'b0};
    n = 0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < BIT_CYC; c++) begin
        if (cut > 0 && n >= cut) return;
        @(negedge clk);
        rxd_a = (i == glitch_bit && c == 4) ? ~f[i] : f[i];
        n++;
      end
    end
    model_a(d, stop);
  endtask

  task automatic tx_b(input logic [6:0] d, input logic par, input logic s1, input logic s2);
    logic [11:0] f;
    f = {1'b1, s2, s1, par, d, 1'b0};
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < BIT_CYC; c++) begin
        @(negedge clk);
        rxd_b = f[i];
      end
    end
    model_b(d, par, s1, s2);
  endtask

  task automatic pop_a(output logic [9:0] w, output bit ok);
    ok = 1'b0;
    w = 'x;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (m_valid_a === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      w = {m_ferr_a, m_perr_a, m_data_a};
      m_ready_a = 1'b1;
      @(negedge clk);
      m_ready_a = 1'b0;
    end
  endtask

  task automatic pop_b(output logic [8:0] w, output bit ok);
    ok = 1'b0;
    w = 'x;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (m_valid_b === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      w = {m_ferr_b, m_perr_b, m_data_b};
      m_ready_b = 1'b1;
      @(negedge clk);
      m_ready_b = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    repeat (4) @(negedge clk);
    n_assert++;
    if ({m_valid_a, m_data_a, m_perr_a, m_ferr_a, overrun_a, busy_a} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_a: got v=%b d=%h p=%b f=%b o=%b busy=%b, expected all 0",
               m_valid_a, m_data_a, m_perr_a, m_ferr_a, overrun_a, busy_a);
    end
    n_assert++;
    if ({m_valid_b, m_data_b, m_perr_b, m_ferr_b, overrun_b, busy_b} !== 12'b0) begin
      n_fail++;
      $display("FAIL reset_b: got v=%b d=%h busy=%b, expected all 0", m_valid_b, m_data_b, busy_b);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [9:0] e;
    bit seen, stable;
    tx_a(8'hA5, 1'b1, -1, 0);
    e = exp_a.pop_front();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (m_valid_a === 1'b1);
    end
    n_assert++;
    if (!seen || {m_ferr_a, m_perr_a, m_data_a} !== e) begin
      n_fail++;
      $display("FAIL basic_word: got v=%b %h, expected %h", m_valid_a, {m_ferr_a, m_perr_a, m_data_a}, e);
    end
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid_a !== 1'b1 || {m_ferr_a, m_perr_a, m_data_a} !== e) stable = 1'b0;
    end
    n_assert++;
    if (!stable) begin
      n_fail++;
      $display("FAIL basic_hold: got v=%b %h while not ready, expected held %h",
               m_valid_a, {m_ferr_a, m_perr_a, m_data_a}, e);
    end
    m_ready_a = 1'b1;
    @(negedge clk);
    m_ready_a = 1'b0;
    n_assert++;
    if (m_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drop: got m_valid=%b after accept, expected 0", m_valid_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] o, e;
    bit ok;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) tx_a(8'($urandom), 1'b1, -1, 0);
      while (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        pop_a(o, ok);
        n_assert++;
        if (!ok || o !== e) begin
          n_fail++;
          $display("FAIL b2b_word: got %h (ok=%0d), expected %h", o, ok, e);
        end
      end
    end
  endtask

  task automatic test_parity();
    logic [8:0] o, e;
    bit ok;
    tx_b(7'h35, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++)
      tx_b(7'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      pop_b(o, ok);
      n_assert++;
      if (!ok || o !== e) begin
        n_fail++;
        $display("FAIL parity_word: got {ferr,perr,data}=%h (ok=%0d), expected %h", o, ok, e);
      end
    end
    @(negedge clk);
    n_assert++;
    if (m_valid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_extra: got m_valid=%b, expected 0", m_valid_b);
    end
  endtask

  task automatic test_break();
    logic [9:0] o, e;
    bit ok, busy_seen;
    tx_a(8'h3C, 1'b0, -1, 0);
    busy_seen = 1'b0;
    for (int i = 0; i < 30 * BIT_CYC; i++) begin
      @(negedge clk);
      if (busy_a !== 1'b0) busy_seen = 1'b1;
    end
    n_assert++;
    if (busy_seen) begin
      n_fail++;
      $display("FAIL break_busy: got busy=1 during held-low line, expected 0");
    end
    rxd_a = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      while (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        pop_a(o, ok);
        n_assert++;
        if (!ok || o !== e) begin
          n_fail++;
          $display("FAIL break_word: got %h (ok=%0d), expected %h", o, ok, e);
        end
      end
      @(negedge clk);
      n_assert++;
      if (m_valid_a !== 1'b0) begin
        n_fail++;
        $display("FAIL break_extra: got m_valid=%b data=%h, expected no further word", m_valid_a, m_data_a);
      end
      if (k == 0) tx_a(8'h55, 1'b1, -1, 0);
    end
  endtask

  task automatic test_false_start();
    bit busy_seen;
    @(negedge clk);
    rxd_a = 1'b0;
    repeat (3) @(negedge clk);
    rxd_a = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy_a === 1'b1) busy_seen = 1'b1;
    end
    n_assert++;
    if (!busy_seen || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL false_start_busy: got pulse=%0d final=%b, expected pulse=1 final=0", busy_seen, busy_a);
    end
    n_assert++;
    if (m_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL false_start_push: got m_valid=%b, expected 0", m_valid_a);
    end
  endtask

  task automatic test_overrun();
    logic [9:0] o, e;
    bit ok;
    for (int k = 1; k <= 4; k++) tx_a(8'(k), 1'b1, -1, 0);
    repeat (4) @(negedge clk);
    n_assert++;
    if (overrun_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_at_full: got overrun=%b with FIFO just full, expected 0", overrun_a);
    end
    tx_a(8'h05, 1'b1, -1, 0);
    repeat (4) @(negedge clk);
    n_assert++;
    if (overrun_a !== ovr_exp_a) begin
      n_fail++;
      $display("FAIL ovr_set: got overrun=%b, expected %b", overrun_a, ovr_exp_a);
    end
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      pop_a(o, ok);
      n_assert++;
      if (!ok || o !== e) begin
        n_fail++;
        $display("FAIL ovr_drain: got %h (ok=%0d), expected %h", o, ok, e);
      end
    end
    @(negedge clk);
    n_assert++;
    if (m_valid_a !== 1'b0 || overrun_a !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: got m_valid=%b overrun=%b, expected 0 and 1", m_valid_a, overrun_a);
    end
    clr_ovr_a = 1'b1;
    @(negedge clk);
    clr_ovr_a = 1'b0;
    ovr_exp_a = 1'b0;
    n_assert++;
    if (overrun_a !== ovr_exp_a) begin
      n_fail++;
      $display("FAIL ovr_clear: got overrun=%b, expected %b", overrun_a, ovr_exp_a);
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] o, e;
    bit ok;
    tx_a(8'h11, 1'b1, -1, 0);
    tx_a(8'h96, 1'b1, -1, 4 * BIT_CYC + 4);
    rstn = 1'b0;
    rxd_a = 1'b1;
    exp_a.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_assert++;
    if (m_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: got m_valid=%b busy=%b, expected 0 0", m_valid_a, busy_a);
    end
    tx_a(8'h96, 1'b1, -1, 0);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      pop_a(o, ok);
      n_assert++;
      if (!ok || o !== e) begin
        n_fail++;
        $display("FAIL midreset_word: got %h (ok=%0d), expected %h", o, ok, e);
      end
    end
    @(negedge clk);
    n_assert++;
    if (m_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_extra: got m_valid=%b, expected 0", m_valid_a);
    end
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority();
    logic [9:0] o, e;
    bit ok;
    tx_a(8'h00, 1'b1, 3, 0);
    tx_a(8'hFF, 1'b1, 6, 0);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      pop_a(o, ok);
      n_assert++;
      if (!ok || o !== e) begin
        n_fail++;
        $display("FAIL majority_glitch: got %h (ok=%0d), expected %h", o, ok, e);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_parity();
    test_break();
    test_false_start();
    test_overrun();
    test_reset_midframe();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_stream.md
# uart_rx_stream

Parametrised UART receiver, successor to the fixed 8N1 receiver. Supports 5–9 data bits, optional odd/even parity, 1 or 2 stop bits, input synchronisation, false-start rejection and break handling. Received words, tagged with per-word error flags, are buffered in a small FIFO and drained through a valid/ready stream. Sits between the board `rxd` pin and the CPU's MMIO/loader logic.

## Interface
- `CLK_PER_HALF_BIT`, 5208: clocks per half bit period; must be ≥ 4.
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `PARITY`, `uart_pkg::PAR_NONE`: one of `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: output FIFO entries; power of 2, ≥ 2.
- `clk`  in  1  clock.
- `rstn`  in  1  reset: synchronous, active-low. Clock is `clk`.
- `rxd`  in  1  asynchronous serial line; idle high.
- `m_data`  out  DATA_BITS  head-of-FIFO data word.
- `m_perr`  out  1  head-word parity error; always 0 when `PARITY == PAR_NONE`.
- `m_ferr`  out  1  head-word framing error.
- `m_valid`  out  1  FIFO not empty.
- `m_ready`  in  1  consumer accepts the head word.
- `overrun`  out  1  sticky: a completed frame was dropped because the FIFO was full.
- `clr_ovr`  in  1  one-cycle pulse that clears `overrun`.
- `busy`  out  1  high in every receiver state except IDLE and BREAK.

## Operation
- `rxd` passes through a 2-FF synchroniser, giving `rxs`. Both flops reset to 1. All logic below uses `rxs`.
- A bit counter `cnt` runs 0..2·CLK_PER_HALF_BIT−1 and wraps. It is cleared on start detection.
- "Sample point" means the cycle where `cnt == CLK_PER_HALF_BIT−1`, i.e. bit centre.
- States (enum in `uart_pkg`):
  - IDLE → START when `rxs == 0`.
  - START, at its sample point: `rxs == 1` → IDLE (false start, nothing pushed); `rxs == 0` → DATA.
  - DATA takes `DATA_BITS` samples, LSB first, into a shift register. Then PARITY if enabled, otherwise STOP.
  - PARITY takes one sample. `perr` = received bit ≠ expected. Expected bit: even parity → XOR of data; odd → its inverse.
  - STOP takes `STOP_BITS` samples. `ferr` = 1 if any stop sample is 0.
  - After the last stop sample: push {ferr, perr, data}. Then go to IDLE if that sample was 1, otherwise to BREAK.
  - BREAK → IDLE when `rxs == 1`. This prevents a held-low line from being decoded as repeated 0x00 frames.
- FIFO rules:
  - Push when full with no pop in the same cycle: word is dropped and `overrun` is set.
  - Push and pop in the same cycle when full: both succeed; count is unchanged.
  - Pop occurs when `m_valid && m_ready`.
  - `clr_ovr` and a new overrun in the same cycle: `overrun` stays 1 (set wins).
- Reset values: `m_valid` 0, `m_data` 0, `m_perr` 0, `m_ferr` 0, `overrun` 0, `busy` 0. State is IDLE, FIFO is empty, `rxs` is 1.
- Reset mid-frame discards the partial frame and the FIFO contents. After release, the receiver waits in IDLE for `rxs == 0`. If the line is still low mid-frame, this yields one frame with ferr set or a false start; this behaviour is accepted.

## Timing
- Synchroniser latency: 2 cycles from `rxd` to `rxs`.
- START is entered 1 cycle after `rxs` falls.
- Start sample point comes CLK_PER_HALF_BIT cycles later. Each subsequent sample comes 2·CLK_PER_HALF_BIT cycles after the previous one.
- Push occurs in the cycle after the last stop sample. `m_valid` rises in the cycle after the push (registered FIFO).
- `m_data`, `m_perr` and `m_ferr` are stable while `m_valid && !m_ready`.
- Stop sample to IDLE: 1 cycle. A new start can therefore be detected within the first half of the stop bit period; back-to-back frames are supported.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each sample (start, data, parity, stop) is the 2-of-3 majority of `rxs` at `cnt` = centre−1, centre and centre+1.
  - The decision is taken at centre+1, and all downstream timing shifts by +1 cycle.
  - Requires CLK_PER_HALF_BIT ≥ 4.
- Undefined: a single sample at centre.

## Structure
- `uart_pkg` holds the parity enum (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`), the receiver state enum, and a `uart_rx_word_t`-style packed layout helper function for {ferr, perr, data}.
- Sub-module `uart_rx_fifo`: synchronous FIFO with full/empty signals, simultaneous push/pop, and width DATA_BITS+2.

## Test plan
- CLK_PER_HALF_BIT=4, 8N1: send 0xA5 → one word, `m_data`=0xA5, perr=0, ferr=0. `m_valid` holds until `m_ready`, then drops.
- DATA_BITS=7, PAR_EVEN, 2 stop bits: send 0x35 with parity bit 1 (incorrect; correct is 0) → `m_data`=0x35, perr=1, ferr=0.
- 8N1: send 0x3C with stop bit 0, then hold `rxd` low for 30 bit periods → exactly one word (0x3C, ferr=1), `busy`=0 in BREAK. After `rxd` returns high, 0x55 is received correctly.
- Drive `rxd` low for 3 cycles only → no word pushed; `busy` pulses, then returns to 0.
- FIFO_DEPTH=4, `m_ready`=0: send 5 frames 0x01..0x05 → 0x01..0x04 drained in order and `overrun`=1. Then `clr_ovr` → `overrun`=0.
- Assert `rstn` low during data bit 3, release, then send 0x96 → FIFO empty after reset, next valid word is 0x96. With `UART_RX_MAJORITY_EN`, a 1-cycle glitch at the centre of a data bit does not flip that bit.
